rv32i_memoryaccess: RTL and testbench

//   MEMORY stage, directly downstream of the EXECUTE-stage ALU. Uses the registered ALU

---
 rtl/rv32i_memoryaccess.sv | 163 ++++++++++++++++
 tb/tb_rv32i_memoryaccess.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_memoryaccess.sv
// MEMORY stage: drives a single-master cyc/stb/ack data bus for loads and stores,
// lane-aligns store data, extracts/extends load data and stalls until completion.
module rv32i_memoryaccess #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_y,
  input  logic [31:0] i_rs2,
  output logic        o_dmem_cyc,
  output logic        o_dmem_stb,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_sel,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] o_load_data,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] tmo_q;
  logic [2:0]       funct3_q;
  logic [1:0]       lane_q;

  logic             illegal_c;
  logic             misaligned_c;
  logic [3:0]       sel_c;
  logic [31:0]      wdata_c;
  logic [31:0]      shifted_c;
  logic [31:0]      load_ext_c;

  // Request decode: legality, alignment, byte-lane enables and replicated store data
  always_comb begin
    illegal_c    = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) ||
                   (i_store && i_funct3[2]);
    sel_c        = 4'b1111;
    wdata_c      = i_rs2;
    misaligned_c = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        sel_c   = 4'b0001 << i_y[1:0];
        wdata_c = {4{i_rs2[7:0]}};
      end
      2'b01: begin
        sel_c        = i_y[1] ? 4'b1100 : 4'b0011;
        wdata_c      = {2{i_rs2[15:0]}};
        misaligned_c = i_y[0];
      end
      default: misaligned_c = |i_y[1:0];
    endcase
  end

  // Load extraction: move the addressed lane to bit 0, then sign/zero-extend
  always_comb begin
    shifted_c = i_dmem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  load_ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b100:  load_ext_c = {24'd0, shifted_c[7:0]};
      3'b101:  load_ext_c = {16'd0, shifted_c[15:0]};
      default: load_ext_c = shifted_c;
    endcase
  end

  // Access FSM with registered bus and pipeline handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      tmo_q         <= '0;
      funct3_q      <= '0;
      lane_q        <= '0;
      o_dmem_cyc    <= 1'b0;
      o_dmem_stb    <= 1'b0;
      o_dmem_we     <= 1'b0;
      o_dmem_addr   <= '0;
      o_dmem_wdata  <= '0;
      o_dmem_sel    <= '0;
      o_load_data   <= '0;
      o_stall       <= 1'b0;
      o_done        <= 1'b0;
      o_fault       <= 1'b0;
      o_fault_cause <= '0;
    end else begin
      o_done  <= 1'b0;
      o_fault <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (!(i_load || i_store)) begin
              state_q <= ST_DONE;
              o_done  <= 1'b1;
            end else if (illegal_c || misaligned_c) begin
              state_q       <= ST_DONE;
              o_done        <= 1'b1;
              o_fault       <= 1'b1;
              o_fault_cause <= illegal_c ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            end else begin
              state_q      <= ST_BUS;
              tmo_q        <= '0;
              funct3_q     <= i_funct3;
              lane_q       <= i_y[1:0];
              o_dmem_cyc   <= 1'b1;
              o_dmem_stb   <= 1'b1;
              o_dmem_we    <= i_store;
              o_dmem_addr  <= {i_y[31:2], 2'b00};
              o_dmem_sel   <= sel_c;
              o_dmem_wdata <= wdata_c;
              o_stall      <= 1'b1;
            end
          end
        end
        ST_BUS: begin
          if (i_dmem_ack) begin
            // Ack takes priority over a coincident timeout
            state_q    <= ST_DONE;
            o_dmem_cyc <= 1'b0;
            o_dmem_stb <= 1'b0;
            o_stall    <= 1'b0;
            o_done     <= 1'b1;
            if (!o_dmem_we) begin
              o_load_data <= load_ext_c;
            end
          end else if (tmo_q == CNT_LAST) begin
            state_q       <= ST_DONE;
            o_dmem_cyc    <= 1'b0;
            o_dmem_stb    <= 1'b0;
            o_stall       <= 1'b0;
            o_done        <= 1'b1;
            o_fault       <= 1'b1;
            o_fault_cause <= CAUSE_TIMEOUT;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_memoryaccess.sv
// Scoreboard bench for rv32i_memoryaccess: directed cases plus randomized traffic.
module tb_rv32i_memoryaccess;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        s_load;
  logic        s_store;
  logic [2:0]  f3;
  logic [31:0] y;
  logic [31:0] rs2;
  logic        dmem_cyc;
  logic        dmem_stb;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_sel;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        stall;
  logic        done;
  logic        fault;
  logic [1:0]  fault_cause;

  rv32i_memoryaccess #(.TIMEOUT(TMO)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_load        (s_load),
    .i_store       (s_store),
    .i_funct3      (f3),
    .i_y           (y),
    .i_rs2         (rs2),
    .o_dmem_cyc    (dmem_cyc),
    .o_dmem_stb    (dmem_stb),
    .o_dmem_we     (dmem_we),
    .o_dmem_addr   (dmem_addr),
    .o_dmem_wdata  (dmem_wdata),
    .o_dmem_sel    (dmem_sel),
    .i_dmem_ack    (dmem_ack),
    .i_dmem_rdata  (dmem_rdata),
    .o_load_data   (load_data),
    .o_stall       (stall),
    .o_done        (done),
    .o_fault       (fault),
    .o_fault_cause (fault_cause)
  );

  typedef struct {
    bit          is_bus;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    bit          fault;
    logic [1:0]  cause;
    logic [31:0] ldata;
    int          c0;
    int          done_cycle;
  } exp_t;

  exp_t        q[$];
  int          cyc_cnt = 0;
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] m_ldata = '0;
  logic [1:0]  m_cause = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", name, cyc_cnt, act, exp);
  endfunction

  // Reference model: derives the whole outcome of one instruction from the architectural rules
  function automatic exp_t build_exp(input bit l, input bit s, input logic [2:0] fn,
                                     input logic [31:0] a, input logic [31:0] d2,
                                     input logic [31:0] rd, input int d, input int c0);
    exp_t   e;
    int     size;
    int     off;
    longint v;
    e.is_bus = 0; e.we = 0; e.addr = '0; e.sel = '0; e.wdata = '0; e.fault = 0;
    e.c0 = c0;
    e.done_cycle = c0 + 1;
    if (!(l || s)) begin
      e.fault = 0;
    end else if (fn == 3 || fn == 6 || fn == 7 || (s && fn >= 4)) begin
      e.fault = 1;
      m_cause = 2'd2;
    end else begin
      case (int'(fn) % 4)
        0:       size = 1;
        1:       size = 2;
        default: size = 4;
      endcase
      off = int'(a % 32'd4);
      if (off % size != 0) begin
        e.fault = 1;
        m_cause = 2'd1;
      end else begin
        e.is_bus = 1;
        e.we     = s;
        e.addr   = a - 32'(off);
        e.sel    = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d2[8*(i % size) +: 8];
        if (d < TMO) begin
          e.done_cycle = c0 + 2 + d;
          if (l) begin
            v = longint'(rd >> (8 * off));
            v = v % (longint'(1) << (8 * size));
            if (fn < 4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
              v = v - (longint'(1) << (8 * size));
            m_ldata = 32'(v);
          end
        end else begin
          e.done_cycle = c0 + 1 + TMO;
          e.fault = 1;
          m_cause = 2'd3;
        end
      end
    end
    e.cause = m_cause;
    e.ldata = m_ldata;
    return e;
  endfunction

  // Monitor: compares bus activity and completion against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].is_bus && cyc_cnt > q[0].c0 && cyc_cnt < q[0].done_cycle) begin
        chk("bus_stb", 32'(dmem_stb), 32'd1);
        chk("bus_cyc", 32'(dmem_cyc), 32'd1);
        chk("bus_stall", 32'(stall), 32'd1);
        chk("bus_we", 32'(dmem_we), 32'(q[0].we));
        chk("bus_addr", dmem_addr, q[0].addr);
        chk("bus_sel", 32'(dmem_sel), 32'(q[0].sel));
        if (q[0].we) chk("bus_wdata", dmem_wdata, q[0].wdata);
      end else begin
        chk("idle_stb", 32'(dmem_stb), 32'd0);
        chk("idle_cyc", 32'(dmem_cyc), 32'd0);
      end
      chk("done_timing", 32'(done), 32'(q.size() > 0 && cyc_cnt == q[0].done_cycle));
      if (done && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("done_fault", 32'(fault), 32'(e.fault));
        chk("fault_cause", 32'(fault_cause), 32'(e.cause));
        chk("load_data", load_data, e.ldata);
        chk("done_stall", 32'(stall), 32'd0);
      end else if (!done) begin
        chk("fault_without_done", 32'(fault), 32'd0);
      end
    end
  end

  task automatic wait_drain();
    int i;
    i = 0;
    while (q.size() != 0 && i < 60) begin
      @(posedge clk);
      i++;
    end
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d transactions outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  // Issue one instruction and act as the bus slave; d = ack cycle index after first stb cycle
  task automatic run_txn(input bit l, input bit s, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] d2, input logic [31:0] rd, input int d);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; s_load = l; s_store = s; f3 = fn; y = a; rs2 = d2;
    e = build_exp(l, s, fn, a, d2, rd, d, cyc_cnt);
    q.push_back(e);
    if (e.is_bus) begin
      for (int k = 0; k < TMO; k++) begin
        @(posedge clk); #1;
        start   = 1'(($urandom % 2));
        s_load  = 1'($urandom % 2);
        s_store = ~s_load;
        f3      = 3'($urandom);
        y       = $urandom;
        rs2     = $urandom;
        dmem_ack   = (k == d);
        dmem_rdata = (k == d) ? rd : $urandom;
        if (k == d) break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; s_load = 1'b0; s_store = 1'b0; dmem_ack = 1'b0;
    wait_drain();
  endtask

  task automatic idle_ack();
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = $urandom;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(posedge clk);
  endtask

  task automatic reset_mid_bus();
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; s_load = 1'b1; s_store = 1'b0; f3 = 3'b010; y = 32'h400; rs2 = '0;
    e = build_exp(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1000, cyc_cnt);
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_cyc", 32'(dmem_cyc), 32'd0);
    chk("rst_stb", 32'(dmem_stb), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    q.delete();
    m_ldata = '0;
    m_cause = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_load = 1'b0; s_store = 1'b0; f3 = '0; y = '0; rs2 = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    #12;
    chk("reset_cyc", 32'(dmem_cyc), 32'd0);
    chk("reset_stb", 32'(dmem_stb), 32'd0);
    chk("reset_addr", dmem_addr, 32'd0);
    chk("reset_load_data", load_data, 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_cause", 32'(fault_cause), 32'd0);
    #8 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_txn(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    run_txn(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF0000, 0);
    run_txn(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF0000, 1);
    run_txn(0, 1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 2);
    run_txn(0, 1, 3'b000, 32'h301, 32'h0000005A, 32'h0, 0);
    run_txn(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    run_txn(1, 0, 3'b001, 32'h103, 32'h0, 32'h0, 0);
    run_txn(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    run_txn(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    run_txn(0, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    run_txn(1, 0, 3'b010, 32'h500, 32'h0, 32'h11111111, 1000);
    run_txn(1, 0, 3'b101, 32'h502, 32'h0, 32'h9ABC0000, TMO - 1);
    reset_mid_bus();
    idle_ack();
    run_txn(1, 0, 3'b010, 32'h600, 32'h0, 32'hCAFEF00D, 1);
    idle_ack();

    for (int n = 0; n < 200; n++) begin
      int          kind;
      bit          l;
      bit          s;
      logic [2:0]  fn;
      logic [2:0]  ld_legal[5];
      ld_legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      kind = $urandom_range(0, 9);
      l = (kind >= 1 && kind <= 5);
      s = (kind >= 6);
      if ($urandom_range(0, 4) == 0) fn = 3'($urandom);
      else if (s) fn = 3'($urandom_range(0, 2));
      else fn = ld_legal[$urandom_range(0, 4)];
      run_txn(l, s, fn, $urandom, $urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? 50 : $urandom_range(0, TMO));
      if ($urandom_range(0, 9) == 0) idle_ack();
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
